// File: rtl/snoop_responder.sv
// snoop_responder: LLC bus-snoop responder (lookup, resolve, L1 notify, writeback); SNOOP_STATS_EN adds outcome counters
module snoop_responder #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 14,
  parameter int TAG_BITS   = 12,
  parameter int WAY_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  snp_valid,
  output logic                  snp_ready,
  input  logic [1:0]            snp_op,
  input  logic [ADDR_W-1:0]     snp_addr,
  output logic                  lk_req,
  output logic [INDEX_BITS-1:0] lk_index,
  output logic [TAG_BITS-1:0]   lk_tag,
  input  logic                  lk_ack,
  input  logic                  lk_hit,
  input  logic [WAY_BITS-1:0]   lk_way,
  input  logic [1:0]            lk_state,
  output logic                  upd_en,
  output logic [INDEX_BITS-1:0] upd_index,
  output logic [WAY_BITS-1:0]   upd_way,
  output logic [1:0]            upd_state,
  output logic                  res_valid,
  output logic [1:0]            res,
  output logic                  l1_valid,
  output logic [1:0]            l1_msg,
  output logic [ADDR_W-1:0]     l1_addr,
  input  logic                  l1_ack,
  output logic                  wb_valid,
  output logic [ADDR_W-1:0]     wb_addr,
  input  logic                  wb_ready,
  output logic                  proto_err
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0]           cnt_hit,
  output logic [15:0]           cnt_hitm,
  output logic [15:0]           cnt_nohit,
  output logic [15:0]           cnt_err
`endif
);
  localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_INV = 2'd2, OP_RWIM = 2'd3;
  localparam logic [1:0] ST_M = 2'd0, ST_E = 2'd1, ST_S = 2'd2, ST_I = 2'd3;
  localparam logic [1:0] R_NOHIT = 2'd0, R_HIT = 2'd1, R_HITM = 2'd2;
  localparam logic [1:0] MSG_GETLINE = 2'd0, MSG_INVLINE = 2'd2;
  typedef enum logic [2:0] {IDLE, LOOKUP, RESOLVE, L1MSG1, L1MSG2, WB} state_t;
  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d, mesi_q, mesi_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  hit_q, hit_d;
  logic [WAY_BITS-1:0]   way_q, way_d;
  logic                  valid_hit, is_m, is_me, inv_s, rd_or_rwim, need_wb, two_msg, need_msg, upd, err, in_res;
  logic [1:0]            rslt;
  logic [INDEX_BITS-1:0] idx;
  logic [ADDR_W-1:0]     line;
  assign idx        = addr_q[6 +: INDEX_BITS];
  assign line       = addr_q & ~ADDR_W'(63);
  assign valid_hit  = hit_q && mesi_q != ST_I;
  assign is_m       = mesi_q == ST_M;
  assign is_me      = is_m || mesi_q == ST_E;
  assign inv_s      = op_q == OP_INV && mesi_q == ST_S;
  assign rd_or_rwim = op_q == OP_READ || op_q == OP_RWIM;
  assign need_wb    = valid_hit && is_m && rd_or_rwim;
  assign two_msg    = valid_hit && is_m && op_q == OP_RWIM;
  assign need_msg   = valid_hit && ((op_q == OP_READ && is_m) || op_q == OP_RWIM || inv_s);
  assign upd        = valid_hit && ((op_q == OP_READ && is_me) || op_q == OP_RWIM || inv_s);
  assign err        = valid_hit && is_me && (op_q == OP_INV || op_q == OP_WRITE);
  assign rslt       = need_wb ? R_HITM : (valid_hit && (rd_or_rwim || inv_s)) ? R_HIT : R_NOHIT;
  assign in_res     = state_q == RESOLVE;
  assign snp_ready  = state_q == IDLE;
  assign lk_req     = state_q == LOOKUP;
  assign lk_index   = lk_req ? idx : '0;
  assign lk_tag     = lk_req ? addr_q[ADDR_W-1 -: TAG_BITS] : '0;
  assign res_valid  = in_res;
  assign res        = in_res ? rslt : R_NOHIT;
  assign proto_err  = in_res && err;
  assign upd_en     = in_res && upd;
  assign upd_index  = upd_en ? idx : '0;
  assign upd_way    = upd_en ? way_q : '0;
  assign upd_state  = upd_en ? (op_q == OP_READ ? ST_S : ST_I) : 2'd0;
  assign l1_valid   = state_q == L1MSG1 || state_q == L1MSG2;
  assign l1_msg     = (l1_valid && !(state_q == L1MSG1 && is_m)) ? MSG_INVLINE : MSG_GETLINE;
  assign l1_addr    = l1_valid ? line : '0;
  assign wb_valid   = state_q == WB;
  assign wb_addr    = wb_valid ? line : '0;
  // state and latched snoop/lookup registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      way_q   <= '0;
      mesi_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      way_q   <= way_d;
      mesi_q  <= mesi_d;
    end
  end
  // next state: accept, wait for lookup, resolve, then L1 messages before any writeback
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    way_d   = way_q;
    mesi_d  = mesi_q;
    case (state_q)
      IDLE: if (snp_valid) begin
        op_d    = snp_op;
        addr_d  = snp_addr;
        state_d = LOOKUP;
      end
      LOOKUP: if (lk_ack) begin
        hit_d   = lk_hit;
        way_d   = lk_way;
        mesi_d  = lk_state;
        state_d = RESOLVE;
      end
      RESOLVE: state_d = need_msg ? L1MSG1 : IDLE;
      L1MSG1:  if (l1_ack) state_d = two_msg ? L1MSG2 : need_wb ? WB : IDLE;
      L1MSG2:  if (l1_ack) state_d = WB;
      WB:      if (wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`ifdef SNOOP_STATS_EN
  // saturating outcome counters, bumped once per resolved snoop
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hit   <= '0;
      cnt_hitm  <= '0;
      cnt_nohit <= '0;
      cnt_err   <= '0;
    end else if (in_res) begin
      if (rslt == R_HIT && !(&cnt_hit)) cnt_hit <= cnt_hit + 16'd1;
      if (rslt == R_HITM && !(&cnt_hitm)) cnt_hitm <= cnt_hitm + 16'd1;
      if (rslt == R_NOHIT && !(&cnt_nohit)) cnt_nohit <= cnt_nohit + 16'd1;
      if (err && !(&cnt_err)) cnt_err <= cnt_err + 16'd1;
    end
  end
`endif
endmodule
